ingame_text_composer: RTL and testbench

- Sequencer that composes the 16-column in-game status line "score:NNN team:T" into a character line buffer.
- Walks the 12-entry in-game string ROM (4-bit address, 7-bit ASCII, combinational read) and converts a binary score to three decimal digits.
- Writes one ASCII character per cycle to the line-buffer write port.
- Sits between game logic (score/team source) and the text renderer's character buffer.

---
 rtl/ingame_text_composer_pkg.sv | 27 ++
 rtl/ingame_text_composer_bin2dec_seq.sv | 71 +++++++
 rtl/ingame_text_composer.sv | 126 ++++++++++++
 tb/tb_ingame_text_composer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ingame_text_composer_pkg.sv
// rtl/ingame_text_composer_pkg.sv - shared states, column map and ASCII constants
// for the in-game status line composer.
package text_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_EMIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [3:0] SCORE_TXT_FIRST = 4'd0;
  localparam logic [3:0] DIGIT_FIRST     = 4'd6;
  localparam logic [3:0] SPACE_COL       = 4'd9;
  localparam logic [3:0] TEAM_TXT_FIRST  = 4'd10;
  localparam logic [3:0] TEAM_DIGIT_COL  = 4'd15;
  localparam logic [3:0] ROM_TEAM_OFFSET = 4'd4;

  localparam logic [6:0] ASCII_ZERO    = 7'h30;
  localparam logic [6:0] ASCII_SPACE   = 7'h20;
  localparam logic [6:0] ASCII_UNKNOWN = 7'h3F;

  function automatic logic [6:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/ingame_text_composer_bin2dec_seq.sv
// rtl/ingame_text_composer_bin2dec_seq.sv - repeated-subtraction binary to
// three-digit decimal converter, one subtraction per cycle after load.
module bin2dec_seq #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] bin_i,
  output logic         ready_o,
  output logic [3:0]   hund_o,
  output logic [3:0]   tens_o,
  output logic [3:0]   units_o
);

  localparam logic [W-1:0] C100 = W'(100);
  localparam logic [W-1:0] C10  = W'(10);

  logic [W-1:0] rem_q, rem_d;
  logic         run_q, run_d;
  logic [3:0]   hund_q, hund_d, tens_q, tens_d, units_q, units_d;

  // ready_o flags the final step: units are captured on this same edge.
  assign ready_o = run_q && (rem_q < C10);
  assign hund_o  = hund_q;
  assign tens_o  = tens_q;
  assign units_o = units_q;

  always_comb begin
    rem_d   = rem_q;
    run_d   = run_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    units_d = units_q;
    if (load_i) begin
      rem_d   = bin_i;
      run_d   = 1'b1;
      hund_d  = 4'd0;
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (run_q) begin
      if (rem_q >= C100) begin
        rem_d  = rem_q - C100;
        hund_d = hund_q + 4'd1;
      end else if (rem_q >= C10) begin
        rem_d  = rem_q - C10;
        tens_d = tens_q + 4'd1;
      end else begin
        units_d = rem_q[3:0];
        run_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q   <= '0;
      run_q   <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      rem_q   <= rem_d;
      run_q   <= run_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/ingame_text_composer.sv
// rtl/ingame_text_composer.sv - composes "score:NNN team:T" into a line buffer,
// one character per cycle. Define LEADING_ZERO_BLANK_EN to blank leading score zeros.
module ingame_text_composer
  import text_pkg::*;
#(
  parameter int COLS      = 16,
  parameter int SCORE_W   = 10,
  parameter int SCORE_MAX = 999
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  input  logic [3:0]         team,
  output logic               busy,
  output logic               done,
  output logic [3:0]         rom_addr,
  input  logic [6:0]         rom_data,
  output logic               wr_en,
  output logic [3:0]         wr_addr,
  output logic [6:0]         wr_data
);

  localparam logic [SCORE_W-1:0] SAT = SCORE_W'(SCORE_MAX);
  localparam logic [3:0]         LAST_COL = 4'(COLS - 1);

  state_t       state_q, state_d;
  logic [3:0]   col_q, col_d;
  logic [6:0]   team_chr_q, team_chr_d;
  logic         conv_load, conv_ready;
  logic [3:0]   hund, tens, units;
  logic [SCORE_W-1:0] score_sat;

  assign score_sat = (score > SAT) ? SAT : score;
  assign conv_load = (state_q == ST_IDLE) && start;

  bin2dec_seq #(.W(SCORE_W)) u_bin2dec (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .load_i  (conv_load),
    .bin_i   (score_sat),
    .ready_o (conv_ready),
    .hund_o  (hund),
    .tens_o  (tens),
    .units_o (units)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    team_chr_d = team_chr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          team_chr_d = (team > 4'd9) ? ASCII_UNKNOWN : digit_char(team);
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_ready) begin
          col_d   = 4'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        col_d = col_q + 4'd1;
        if (col_q == LAST_COL) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      col_q      <= 4'd0;
      team_chr_q <= 7'd0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      team_chr_q <= team_chr_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  // Column map: ROM text, three digits, space, ROM text, team character.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 7'd0;
    rom_addr = 4'd0;
    if (state_q == ST_EMIT) begin
      wr_en   = 1'b1;
      wr_addr = col_q;
      if (col_q < DIGIT_FIRST) begin
        rom_addr = col_q - SCORE_TXT_FIRST;
        wr_data  = rom_data;
      end else if (col_q == DIGIT_FIRST) begin
`ifdef LEADING_ZERO_BLANK_EN
        wr_data = (hund == 4'd0) ? ASCII_SPACE : digit_char(hund);
`else
        wr_data = digit_char(hund);
`endif
      end else if (col_q == DIGIT_FIRST + 4'd1) begin
`ifdef LEADING_ZERO_BLANK_EN
        wr_data = (hund == 4'd0 && tens == 4'd0) ? ASCII_SPACE : digit_char(tens);
`else
        wr_data = digit_char(tens);
`endif
      end else if (col_q == DIGIT_FIRST + 4'd2) begin
        wr_data = digit_char(units);
      end else if (col_q == SPACE_COL) begin
        wr_data = ASCII_SPACE;
      end else if (col_q >= TEAM_TXT_FIRST && col_q < TEAM_DIGIT_COL) begin
        rom_addr = col_q - ROM_TEAM_OFFSET;
        wr_data  = rom_data;
      end else begin
        wr_data = team_chr_q;
      end
    end
  end

endmodule

// File: tb/tb_ingame_text_composer.sv
// tb/tb_ingame_text_composer.sv - self-checking bench for ingame_text_composer.
module tb_ingame_text_composer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] score = '0;
  logic [3:0] team = '0;
  logic       busy, done, wr_en;
  logic [3:0] rom_addr, wr_addr;
  logic [6:0] rom_data, wr_data;

  logic [6:0] rom [0:11];
  int n_checks = 0;
  int n_fail = 0;

  ingame_text_composer dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .score(score), .team(team),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 Clk = ~Clk;

  assign rom_data = (rom_addr < 4'd12) ? rom[rom_addr] : 7'h7F;

  initial begin
    string s;
    byte   b;
    s = "score:team:#";
    for (int i = 0; i < 12; i++) begin
      b = s[i];
      rom[i] = b[6:0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int sat(input int s);
    return (s > 999) ? 999 : s;
  endfunction

  function automatic int model_latency(input int s);
    return sat(s) / 100 + (sat(s) / 10) % 10 + 18;
  endfunction

  function automatic logic [6:0] model_char(input int s, input int t, input int col);
    string ln;
    byte   b;
`ifdef LEADING_ZERO_BLANK_EN
    ln = $sformatf("score:%3d team:", sat(s));
`else
    ln = $sformatf("score:%03d team:", sat(s));
`endif
    ln = {ln, (t > 9) ? "?" : $sformatf("%0d", t)};
    b = ln[col];
    return b[6:0];
  endfunction

  function automatic logic [3:0] model_rom(input int col);
    if (col < 6) return 4'(col);
    if (col >= 10 && col <= 14) return 4'(col - 4);
    return 4'd0;
  endfunction

  task automatic run_line(input int s, input int t, input int exp_lat, input bit noisy, input bit post);
    int lat = -1;
    int wcount = 0;
    bit busy_ok = 1'b1, addr_ok = 1'b1, rom_ok = 1'b1, idle_ok = 1'b1;
    logic [6:0] got [16];
    for (int c = 0; c < 16; c++) got[c] = 7'h00;
    @(negedge Clk);
    score = s[9:0];
    team  = t[3:0];
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    score = ~score;
    team  = ~team;
    for (int n = 1; n <= 60; n++) begin
      @(negedge Clk);
      if (!busy) busy_ok = 1'b0;
      if (wr_en) begin
        if (wr_addr != 4'(wcount)) addr_ok = 1'b0;
        got[wr_addr] = wr_data;
        if (rom_addr != model_rom(int'(wr_addr))) rom_ok = 1'b0;
        wcount++;
      end else if (rom_addr != 4'd0) begin
        rom_ok = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
      start = noisy && (n % 2 == 1);
    end
    start = 1'b0;
    check($sformatf("latency s=%0d", s), lat, exp_lat);
    check($sformatf("write_count s=%0d", s), wcount, 16);
    check($sformatf("write_order s=%0d", s), addr_ok, 1);
    check($sformatf("rom_seq s=%0d", s), rom_ok, 1);
    check($sformatf("busy_held s=%0d", s), busy_ok, 1);
    for (int c = 0; c < 16; c++)
      check($sformatf("char s=%0d t=%0d col=%0d", s, t, c), got[c], model_char(s, t, c));
    if (post) begin
      repeat (4) begin
        @(negedge Clk);
        if (busy || done || wr_en) idle_ok = 1'b0;
      end
      check($sformatf("idle_after s=%0d", s), idle_ok, 1);
    end
  endtask

  typedef struct {
    int score;
    int team;
    int lat;
  } vec_t;

  initial begin
    vec_t tv [7];
    bit   found;
    bit   quiet;
    int   rs, rt;

    tv[0] = '{0, 3, 18};
    tv[1] = '{999, 9, 36};
    tv[2] = '{1023, 12, 36};
    tv[3] = '{405, 5, 22};
    tv[4] = '{250, 7, 25};
    tv[5] = '{90, 10, 27};
    tv[6] = '{1, 0, 18};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", {busy, done, wr_en, wr_addr, wr_data, rom_addr}, 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_line(tv[i].score, tv[i].team, tv[i].lat, tv[i].score == 405, 1'b1);

    // Reset while column 7 is being written.
    @(negedge Clk);
    score = 10'd999;
    team  = 4'd9;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clk);
      if (wr_en && wr_addr == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_col7", found, 1);
    Reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, wr_en, wr_addr, wr_data, rom_addr}, 0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge Clk);
      if (busy || done || wr_en) quiet = 1'b0;
    end
    check("quiet_after_reset", quiet, 1);
    run_line(42, 1, 22, 1'b0, 1'b1);

    // Back-to-back: second start lands in the IDLE cycle right after DONE.
    run_line(123, 4, 21, 1'b0, 1'b0);
    run_line(7, 2, 18, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      rs = int'($urandom_range(0, 1023));
      rt = int'($urandom_range(0, 15));
      run_line(rs, rt, model_latency(rs), i % 4 == 0, i % 2 == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
